// File: rtl/instr_issue_unit_pkg.sv
// Shared definitions for the instruction issue unit: the instruction word layout,
// the special opcodes, the FSM state encoding and the field-extraction helpers.
package instr_issue_unit_pkg;

   localparam int INSTR_W  = 49;
   localparam int REG_W    = 4;
   localparam int OPC_W    = 5;
   localparam int IMM_W    = 32;

   localparam int OPC_LSB  = 44;
   localparam int S1_LSB   = 40;
   localparam int S2_LSB   = 36;
   localparam int DEST_LSB = 32;
   localparam int IMM_LSB  = 0;

   localparam logic [OPC_W-1:0]   NOP_OPCODE  = 5'h00;
   localparam logic [OPC_W-1:0]   HALT_OPCODE = 5'h1F;
   localparam logic [INSTR_W-1:0] NOP_INSTR   = {NOP_OPCODE, 44'd0};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } issue_state_t;

   function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
      return instr[OPC_LSB +: OPC_W];
   endfunction

   function automatic logic [REG_W-1:0] instr_s1(input logic [INSTR_W-1:0] instr);
      return instr[S1_LSB +: REG_W];
   endfunction

   function automatic logic [REG_W-1:0] instr_s2(input logic [INSTR_W-1:0] instr);
      return instr[S2_LSB +: REG_W];
   endfunction

   function automatic logic [REG_W-1:0] instr_dest(input logic [INSTR_W-1:0] instr);
      return instr[DEST_LSB +: REG_W];
   endfunction

   function automatic logic [IMM_W-1:0] instr_imm(input logic [INSTR_W-1:0] instr);
      return instr[IMM_LSB +: IMM_W];
   endfunction

endpackage

// File: rtl/instr_issue_unit_scoreboard.sv
// Destination scoreboard: remembers the dest registers of the last HAZ_DEPTH issue
// slots and flags a read-after-write hazard for the candidate instruction's sources.
module issue_scoreboard
   import instr_issue_unit_pkg::*;
#(
   parameter int HAZ_DEPTH = 3
) (
   input  logic             sys_clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             shift,
   input  logic             push_valid,
   input  logic [REG_W-1:0] push_dest,
   input  logic [REG_W-1:0] src1,
   input  logic [REG_W-1:0] src2,
   output logic             hazard
);

   logic             valid_q [HAZ_DEPTH];
   logic [REG_W-1:0] dest_q  [HAZ_DEPTH];

   // Shift register of in-flight dests; slot 0 is the most recent issue slot, r0 never tracked
   always_ff @(posedge sys_clk) begin
      if (!reset_n || clear) begin
         for (int i = 0; i < HAZ_DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            dest_q[i]  <= '0;
         end
      end else if (shift) begin
         valid_q[0] <= push_valid && (push_dest != '0);
         dest_q[0]  <= push_dest;
         for (int i = 1; i < HAZ_DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            dest_q[i]  <= dest_q[i-1];
         end
      end
   end

   // A source matching any still-valid in-flight dest must wait
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
         if (valid_q[i] && ((dest_q[i] == src1) || (dest_q[i] == src2))) begin
            hazard = 1'b1;
         end
      end
   end

endmodule

// File: rtl/instr_issue_unit.sv
// Instruction issue unit: program RAM, PC and run FSM feeding the pipelined
// controller one registered instruction (or NOP bubble) per cycle.
module instr_issue_unit
   import instr_issue_unit_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int HAZ_DEPTH = 3
) (
   input  logic               sys_clk,
   input  logic               reset_n,
   input  logic               ld_en,
   input  logic [AW-1:0]      ld_addr,
   input  logic [INSTR_W-1:0] ld_instr,
   input  logic [AW:0]        prog_len,
   input  logic               start,
   input  logic               abort,
   output logic [OPC_W-1:0]   opcode_out,
   output logic [REG_W-1:0]   s1_out,
   output logic [REG_W-1:0]   s2_out,
   output logic [REG_W-1:0]   dest_out,
   output logic [IMM_W-1:0]   ime_data_out,
   output logic               busy,
   output logic               done,
   output logic [15:0]        stall_cnt
);

   localparam int          DCW    = $clog2(HAZ_DEPTH + 1);
   localparam logic [AW:0] PC_ONE = 1;

   logic [INSTR_W-1:0] ram [DEPTH];

   issue_state_t       state_q, state_d;
   logic [AW:0]        pc_q, pc_d;
   logic [AW:0]        len_q, len_d;
   logic [15:0]        stall_q, stall_d;
   logic [DCW-1:0]     drain_q, drain_d;
   logic [INSTR_W-1:0] out_q, out_d;

   logic [INSTR_W-1:0] cur_instr;
   logic               hazard;
   logic               sb_clear;
   logic               sb_shift;
   logic               sb_push;

   assign cur_instr = ram[pc_q[AW-1:0]];

   issue_scoreboard #(
      .HAZ_DEPTH (HAZ_DEPTH)
   ) u_scoreboard (
      .sys_clk    (sys_clk),
      .reset_n    (reset_n),
      .clear      (sb_clear),
      .shift      (sb_shift),
      .push_valid (sb_push),
      .push_dest  (instr_dest(cur_instr)),
      .src1       (instr_s1(cur_instr)),
      .src2       (instr_s2(cur_instr)),
      .hazard     (hazard)
   );

   // Program loading is only accepted while idle; contents survive reset
   always_ff @(posedge sys_clk) begin
      if (ld_en && (state_q == ST_IDLE)) begin
         ram[ld_addr] <= ld_instr;
      end
   end

   // Next-state, PC, drain counter and issue selection; abort overrides every transition
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      len_d    = len_q;
      stall_d  = stall_q;
      drain_d  = drain_q;
      out_d    = NOP_INSTR;
      sb_clear = 1'b0;
      sb_shift = 1'b0;
      sb_push  = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_RUN;
               pc_d     = '0;
               len_d    = prog_len;
               stall_d  = '0;
               sb_clear = 1'b1;
            end
         end
         ST_RUN: begin
            sb_shift = 1'b1;
            if ((pc_q == len_q) || (instr_opcode(cur_instr) == HALT_OPCODE)) begin
               state_d = ST_DRAIN;
               drain_d = DCW'(HAZ_DEPTH - 1);
            end else if (hazard) begin
               if (stall_q != 16'hFFFF) begin
                  stall_d = stall_q + 16'd1;
               end
            end else begin
               out_d   = cur_instr;
               pc_d    = pc_q + PC_ONE;
               sb_push = 1'b1;
            end
         end
         ST_DRAIN: begin
            sb_shift = 1'b1;
            if (drain_q == '0) begin
               state_d = ST_DONE;
            end else begin
               drain_d = drain_q - DCW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort) begin
         state_d  = ST_IDLE;
         pc_d     = '0;
         len_d    = len_q;
         stall_d  = stall_q;
         drain_d  = drain_q;
         out_d    = NOP_INSTR;
         sb_clear = 1'b1;
         sb_shift = 1'b0;
         sb_push  = 1'b0;
      end
   end

   // Control state and the registered pipeline-facing instruction
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         len_q   <= '0;
         stall_q <= '0;
         drain_q <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         len_q   <= len_d;
         stall_q <= stall_d;
         drain_q <= drain_d;
         out_q   <= out_d;
      end
   end

   assign opcode_out   = instr_opcode(out_q);
   assign s1_out       = instr_s1(out_q);
   assign s2_out       = instr_s2(out_q);
   assign dest_out     = instr_dest(out_q);
   assign ime_data_out = instr_imm(out_q);
   assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done         = (state_q == ST_DONE);
   assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_instr_issue_unit.sv
// Self-checking bench for instr_issue_unit: directed scenarios plus random programs
// compared against a cycle-indexed issue-timeline model of the program.
module tb_instr_issue_unit;
   import instr_issue_unit_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int HAZ   = 3;

   logic          sys_clk = 1'b0;
   logic          reset_n;
   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [48:0]   ld_instr;
   logic [AW:0]   prog_len;
   logic          start;
   logic          abort;
   logic [4:0]    opcode_out;
   logic [3:0]    s1_out;
   logic [3:0]    s2_out;
   logic [3:0]    dest_out;
   logic [31:0]   ime_data_out;
   logic          busy;
   logic          done;
   logic [15:0]   stall_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [48:0] instr;
      logic        busy;
      logic        done;
   } obs_t;

   logic [48:0] prog [DEPTH];
   obs_t        exp_q [$];
   int          exp_stalls;

   instr_issue_unit dut (
      .sys_clk      (sys_clk),
      .reset_n      (reset_n),
      .ld_en        (ld_en),
      .ld_addr      (ld_addr),
      .ld_instr     (ld_instr),
      .prog_len     (prog_len),
      .start        (start),
      .abort        (abort),
      .opcode_out   (opcode_out),
      .s1_out       (s1_out),
      .s2_out       (s2_out),
      .dest_out     (dest_out),
      .ime_data_out (ime_data_out),
      .busy         (busy),
      .done         (done),
      .stall_cnt    (stall_cnt)
   );

   // Free-running clock
   always #5 sys_clk = ~sys_clk;

   function automatic logic [48:0] mk(input logic [4:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] d,
                                      input logic [31:0] imm);
      return {op, a, b, d, imm};
   endfunction

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic load_program(input int n);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int i = 0; i < n; i++) begin
         ld_en    = 1'b1;
         ld_addr  = 4'(i);
         ld_instr = prog[i];
         tick();
      end
      ld_en = 1'b0;
   endtask

   // Observation k is taken just after the k-th edge following the start edge.
   // An instruction issued at cycle k may not read a register written by one issued
   // within the previous HAZ cycles; the end of the program is followed by HAZ NOPs.
   task automatic build_expected(input int len);
      int  last_issue [16];
      int  pc;
      int  k;
      int  a;
      int  b;
      bit  fin;
      obs_t nop_busy;
      obs_t nop_done;
      nop_busy = '{instr: 49'd0, busy: 1'b1, done: 1'b0};
      nop_done = '{instr: 49'd0, busy: 1'b0, done: 1'b1};
      exp_q.delete();
      exp_stalls = 0;
      foreach (last_issue[r]) last_issue[r] = -100;
      exp_q.push_back(nop_busy);
      pc  = 0;
      k   = 1;
      fin = 1'b0;
      while (!fin) begin
         if (pc == len) fin = 1'b1;
         else if (prog[pc][48:44] == 5'h1F) fin = 1'b1;
         if (fin) begin
            exp_q.push_back(nop_busy);
         end else begin
            a = int'(prog[pc][43:40]);
            b = int'(prog[pc][39:36]);
            if ((a != 0 && k - last_issue[a] <= HAZ) || (b != 0 && k - last_issue[b] <= HAZ)) begin
               exp_q.push_back(nop_busy);
               exp_stalls++;
            end else begin
               exp_q.push_back('{instr: prog[pc], busy: 1'b1, done: 1'b0});
               last_issue[int'(prog[pc][35:32])] = k;
               pc++;
            end
         end
         k++;
      end
      for (int d = 1; d < HAZ; d++) exp_q.push_back(nop_busy);
      exp_q.push_back(nop_done);
   endtask

   // Pulses start (optionally with a same-cycle write to entry 0) and checks every cycle
   task automatic run_check(input string name, input int len, input bit ld_on_start,
                            input logic [48:0] ld_val);
      logic [50:0] got;
      logic [50:0] want;
      prog_len = 5'(len);
      start    = 1'b1;
      if (ld_on_start) begin
         ld_en    = 1'b1;
         ld_addr  = '0;
         ld_instr = ld_val;
      end
      tick();
      start = 1'b0;
      ld_en = 1'b0;
      foreach (exp_q[i]) begin
         if (i > 0) tick();
         got  = {busy, done, opcode_out, s1_out, s2_out, dest_out, ime_data_out};
         want = {exp_q[i].busy, exp_q[i].done, exp_q[i].instr};
         checks++;
         if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s cycle %0d: got busy=%b done=%b instr=%h, want busy=%b done=%b instr=%h",
                     name, i, got[50], got[49], got[48:0], want[50], want[49], want[48:0]);
         end
      end
      checks++;
      if (stall_cnt !== 16'(exp_stalls)) begin
         failures++;
         $display("[TB] FAIL %s stall_cnt: got %0d, want %0d", name, stall_cnt, exp_stalls);
      end
   endtask

   task automatic check_idle_zero(input string name, input logic [15:0] want_stalls);
      checks++;
      if ({busy, done, opcode_out, s1_out, s2_out, dest_out, ime_data_out, stall_cnt} !==
          {2'b00, 49'd0, want_stalls}) begin
         failures++;
         $display("[TB] FAIL %s: got busy=%b done=%b op=%h s1=%h s2=%h dest=%h imm=%h stall=%0d, want zeros stall=%0d",
                  name, busy, done, opcode_out, s1_out, s2_out, dest_out, ime_data_out,
                  stall_cnt, want_stalls);
      end
   endtask

   task automatic set_raw_program();
      prog[0] = mk(5'h03, 4'd5, 4'd6, 4'd1, 32'h1111_0000);
      prog[1] = mk(5'h04, 4'd1, 4'd7, 4'd2, 32'h2222_0000);
   endtask

   task automatic test_reset();
      tick();
      tick();
      check_idle_zero("reset_initial", 16'd0);
      reset_n = 1'b1;
      set_raw_program();
      load_program(2);
      prog_len = 5'd2;
      start    = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      tick();
      check_idle_zero("reset_mid_run", 16'd0);
      reset_n = 1'b1;
      tick();
      check_idle_zero("reset_release_idle", 16'd0);
      build_expected(2);
      run_check("reset_ram_kept", 2, 1'b0, '0);
   endtask

   task automatic test_no_hazard();
      for (int i = 0; i < 4; i++) begin
         prog[i] = mk(5'(i + 1), 4'(5 + i), 4'(8 - i), 4'(1 + i), 32'hA000_0000 + 32'(i));
      end
      load_program(4);
      build_expected(4);
      run_check("no_hazard", 4, 1'b0, '0);
   endtask

   task automatic test_raw();
      set_raw_program();
      load_program(2);
      build_expected(2);
      run_check("raw", 2, 1'b0, '0);
      checks++;
      if (stall_cnt !== 16'd3) begin
         failures++;
         $display("[TB] FAIL raw_stalls: got %0d, want 3", stall_cnt);
      end
   endtask

   task automatic test_gap();
      prog[0] = mk(5'h05, 4'd5, 4'd6, 4'd2, 32'h0000_00AA);
      prog[1] = mk(5'h06, 4'd7, 4'd8, 4'd3, 32'h0000_00BB);
      prog[2] = mk(5'h07, 4'd9, 4'd2, 4'd4, 32'h0000_00CC);
      load_program(3);
      build_expected(3);
      run_check("gap", 3, 1'b0, '0);
      checks++;
      if (stall_cnt !== 16'd2) begin
         failures++;
         $display("[TB] FAIL gap_stalls: got %0d, want 2", stall_cnt);
      end
   endtask

   task automatic test_halt();
      for (int i = 0; i < 8; i++) begin
         prog[i] = mk(5'h08, 4'd9, 4'd10, 4'(11 + (i % 4)), 32'hC0DE_0000 + 32'(i));
      end
      prog[2] = mk(5'h1F, 4'd0, 4'd0, 4'd0, 32'hDEAD_BEEF);
      load_program(8);
      build_expected(8);
      run_check("halt", 8, 1'b0, '0);
   endtask

   task automatic test_abort();
      set_raw_program();
      load_program(2);
      prog_len = 5'd2;
      start    = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_idle_zero("abort_idle", 16'd1);
      tick();
      check_idle_zero("abort_stays_idle", 16'd1);
      build_expected(2);
      run_check("abort_rerun", 2, 1'b0, '0);
   endtask

   task automatic test_len_zero();
      build_expected(0);
      run_check("len_zero", 0, 1'b0, '0);
   endtask

   task automatic test_load_with_start();
      prog[0] = mk(5'h09, 4'd5, 4'd6, 4'd3, 32'h0000_0001);
      prog[1] = mk(5'h0A, 4'd3, 4'd6, 4'd4, 32'h0000_0002);
      prog[2] = mk(5'h0B, 4'd7, 4'd8, 4'd5, 32'h0000_0003);
      load_program(3);
      prog[0] = mk(5'h0C, 4'd9, 4'd10, 4'd6, 32'h5555_AAAA);
      build_expected(3);
      run_check("load_with_start", 3, 1'b1, prog[0]);
   endtask

   task automatic test_done_ignores_load();
      ld_en    = 1'b1;
      ld_addr  = 4'd0;
      ld_instr = mk(5'h1F, 4'd0, 4'd0, 4'd0, 32'hBAD0_BAD0);
      tick();
      ld_en = 1'b0;
      build_expected(3);
      run_check("done_ignores_load", 3, 1'b0, '0);
   endtask

   task automatic test_random();
      int len;
      for (int it = 0; it < 25; it++) begin
         for (int i = 0; i < DEPTH; i++) begin
            prog[i] = mk(5'($urandom_range(1, 30)), 4'($urandom_range(0, 7)),
                         4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), $urandom);
            if (it != 0 && $urandom_range(0, 9) == 0) prog[i][48:44] = 5'h1F;
         end
         len = (it == 0) ? DEPTH : int'($urandom_range(0, DEPTH));
         load_program(DEPTH);
         build_expected(len);
         run_check($sformatf("random_%0d", it), len, 1'b0, '0);
      end
   endtask

   // Scenario sequence
   initial begin
      reset_n  = 1'b0;
      ld_en    = 1'b0;
      ld_addr  = '0;
      ld_instr = '0;
      prog_len = '0;
      start    = 1'b0;
      abort    = 1'b0;
      test_reset();
      test_no_hazard();
      test_raw();
      test_gap();
      test_halt();
      test_abort();
      test_len_zero();
      test_load_with_start();
      test_done_ignores_load();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
